param_mdu: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS core's EX stage, the next generation of the fixed 32-bit MDU behind the core's start/busy handshake. It executes MULT/MULTU/DIV/DIVU with independently configurable latencies, handles MTHI/MTLO, and owns the HI/LO registers. It adds a cancel input so the exception/interrupt flush can abort an in-flight operation without corrupting HI/LO.

---
 rtl/param_mdu.sv | 150 +++++++++++++++
 tb/tb_param_mdu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mdu.sv
// Multiply/divide unit with HI/LO ownership; MADD/MSUB family enabled by MDU_MADD_EN.
// Latency: MUL_LAT (mul/madd) or DIV_LAT (div) edges from accept; MTHI/MTLO write at the accepting edge.
// Backpressure: busy blocks new starts, which are dropped while busy; cancel aborts in flight, HI/LO untouched.
module param_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
`endif

  logic               op_valid;
  logic               accept;
  logic [2*WIDTH-1:0] mul_s;
  logic [2*WIDTH-1:0] mul_u;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] res;

  assign busy   = (cnt_q != '0);
  assign accept = start & ~cancel & ~busy & op_valid;

  always_comb begin
    op_valid = 1'b0;
    if (op >= OP_MULT && op <= OP_MTLO)
      op_valid = 1'b1;
    else if (op >= OP_MADD && op <= OP_MSUBU)
      op_valid = MADD_EN;
  end

  // Result datapath works off captured operands; only sampled on the completion edge.
  always_comb begin
    mul_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    mul_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    quo   = '1;
    rem   = a_q;
    if (b_q != '0) begin
      if (op_q == OP_DIVU) begin
        quo = a_q / b_q;
        rem = a_q % b_q;
      end else if (a_q == SMIN && b_q == '1) begin
        quo = SMIN;
        rem = '0;
      end else begin
        quo = $signed(a_q) / $signed(b_q);
        rem = $signed(a_q) % $signed(b_q);
      end
    end
  end

  always_comb begin
    res = {hi, lo};
    case (op_q)
      OP_MULT:         res = mul_s;
      OP_MULTU:        res = mul_u;
      OP_DIV, OP_DIVU: res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD:         res = acc_q + mul_s;
      OP_MADDU:        res = acc_q + mul_u;
      OP_MSUB:         res = acc_q - mul_s;
      OP_MSUBU:        res = acc_q - mul_u;
`endif
      default:         res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
`ifdef MDU_MADD_EN
      acc_q <= '0;
`endif
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        // cancel outranks the completion edge so a flushed result never lands
        if (cancel) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            {hi, lo} <= res;
            done     <= 1'b1;
          end
        end
      end else if (accept) begin
        if (op == OP_MTHI) begin
          hi <= a;
        end else if (op == OP_MTLO) begin
          lo <= a;
        end else begin
          a_q   <= a;
          b_q   <= b;
          op_q  <= op;
`ifdef MDU_MADD_EN
          acc_q <= {hi, lo};
`endif
          cnt_q <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end
      end
    end
  end

endmodule

// File: tb/tb_param_mdu.sv
// Bench for param_mdu: directed cases with literal expectations plus random traffic
// against a transaction-level model of the unit.
module tb_param_mdu;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  param_mdu #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_valid(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1) && (o <= 4'd10);
`else
    return (o >= 4'd1) && (o <= 4'd6);
`endif
  endfunction

  function automatic int model_lat(input logic [3:0] o);
    return (o == OP_DIV || o == OP_DIVU) ? 10 : 5;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc);
    longint sx, sy;
    logic [63:0] ps, pu;
    logic [31:0] ux, uy, qm, rm, q, r;
    sx = $signed(x);
    sy = $signed(y);
    ps = 64'(sx * sy);
    pu = {32'd0, x} * {32'd0, y};
    if (o == OP_DIV || o == OP_DIVU) begin
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o == OP_DIVU) return {x % y, x / y};
      // sign-magnitude long division: MIN/-1 wraps back to MIN naturally
      ux = x[31] ? -x : x;
      uy = y[31] ? -y : y;
      qm = ux / uy;
      rm = ux % uy;
      q  = (x[31] ^ y[31]) ? -qm : qm;
      r  = x[31] ? -rm : rm;
      return {r, q};
    end
    case (o)
      4'd1:    return ps;
      4'd2:    return pu;
      4'd7:    return acc + ps;
      4'd8:    return acc + pu;
      4'd9:    return acc - ps;
      4'd10:   return acc - pu;
      default: return acc;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] pend_res;
  bit          pend, exp_done;
  int          ecyc = 0;
  int          pend_end = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0; exp_done = 1'b0;
    end else begin
      ecyc++;
      exp_done = 1'b0;
      if (pend) begin
        if (cancel) pend = 1'b0;
        else if (ecyc == pend_end) begin
          {m_hi, m_lo} = pend_res;
          pend = 1'b0;
          exp_done = 1'b1;
        end
      end else if (start && !cancel && model_valid(op)) begin
        if (op == OP_MTHI) m_hi = a;
        else if (op == OP_MTLO) m_lo = a;
        else begin
          pend     = 1'b1;
          pend_end = ecyc + model_lat(op);
          pend_res = model_result(op, a, b, {m_hi, m_lo});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      if (busy !== pend || done !== exp_done || hi !== m_hi || lo !== m_lo) begin
        fails++;
        $display("FAIL cycle_check t=%0t: got busy=%b done=%b hi=%h lo=%h, expected busy=%b done=%b hi=%h lo=%h",
                 $time, busy, done, hi, lo, pend, exp_done, m_hi, m_lo);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic measure(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int dcount;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    measure(n);
    check("mult_lat", 32'(n), 32'd5);
    check("mult_done", 32'(done), 32'd1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    measure(n);
    check("b2b_lat", 32'(n), 32'd5);
    check("b2b_hi", hi, 32'd1);
    check("b2b_lo", lo, 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    issue(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    measure(n);
    check("multu_hi", hi, 32'h0000_0006);
    check("multu_lo", lo, 32'hFFFF_FFEB);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    measure(n);
    check("div_lat", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd0);
    measure(n);
    check("divu0_hi", hi, 32'd7);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    measure(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    issue(OP_MTLO, 32'h1234, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_lo", lo, 32'h1234);
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    check("mthi_hi", hi, 32'h11);

    // cancel in cycle 3 of a divide
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_done", 32'(done), 32'd0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);
    @(negedge clk);
    check("cancel_no_late_done", 32'(done), 32'd0);

    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    check("start_cancel_busy", 32'(busy), 32'd0);

    // cancel on the completion cycle
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_last_busy", 32'(busy), 32'd0);
    check("cancel_last_done", 32'(done), 32'd0);
    check("cancel_last_lo", lo, 32'h22);

    // starts during busy are dropped
    issue(OP_MULT, 32'd2, 32'd3);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    op = OP_MTHI; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    measure(n);
    check("busy_ign_lat", 32'(n), 32'd3);
    check("busy_ign_hi", hi, 32'd0);
    check("busy_ign_lo", lo, 32'd6);
    @(negedge clk);
    check("busy_ign_idle", 32'(busy), 32'd0);

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    measure(n);
    check("madd_lat", 32'(n), 32'd5);
    check("madd_lo", lo, 32'd11);
    check("madd_hi", hi, 32'd0);
    issue(OP_MSUBU, 32'd4, 32'd4);
    measure(n);
    check("msubu_lo", lo, 32'hFFFF_FFFB);
    check("msubu_hi", hi, 32'hFFFF_FFFF);
`else
    issue(OP_MTHI, 32'hAB, 32'd0);
    issue(OP_MTLO, 32'hCD, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    check("madd_off_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("madd_off_hi", hi, 32'hAB);
    check("madd_off_lo", lo, 32'hCD);
`endif

    // asynchronous reset in the middle of a divide
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("arst_no_done", 32'(dcount), 32'd0);
    check("arst_lo_after", lo, 32'd0);

    // random traffic, checked every cycle by the compare process
    repeat (2500) begin
      start  = ($urandom_range(2) == 0);
      op     = 4'($urandom_range(15));
      cancel = ($urandom_range(11) == 0);
      a      = rnd_val();
      b      = rnd_val();
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
